// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// One radix-2 step per cycle: shift-add multiply on operand magnitudes,
// restoring shift-subtract divide; sign correction happens in a final
// FIX cycle. All outputs come straight from flops.
// Optional build macro: MULDIV_ZERO_SHORTCUT_EN -- when defined, a zero
// operandB at start skips the iteration phase and goes straight to FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;      // product / quotient sign
  logic             neg_hi_q, neg_hi_d;      // remainder sign (dividend sign)
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;      // partial product high / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;      // multiplier bits / quotient bits
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode: even op codes are the signed variants.
  logic             signed_op;
  logic             op_is_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  assign signed_op = ~op[0];
  assign op_is_div = op[1];
  assign mag_a = (signed_op && operandA[WIDTH-1]) ? (~operandA + 1'b1) : operandA;
  assign mag_b = (signed_op && operandB[WIDTH-1]) ? (~operandB + 1'b1) : operandB;

  // One multiply step: conditionally add, then shift {carry,hi,lo} right.
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring divide step: shift in the next dividend bit, trial subtract.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};

  // Final sign corrections.
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_neg;
  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod_mag + 1'b1;

  // Next-state and datapath computation for every register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (hiWrite) hi_d = writeData;
        if (loWrite) lo_d = writeData;
        if (start && !flush) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op_is_div;
          neg_lo_d   = signed_op & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
          neg_hi_d   = signed_op & operandA[WIDTH-1];
          div_zero_d = op_is_div && (operandB == '0);
          opnd_d     = op_is_div ? mag_b : mag_a;
          acc_hi_d   = '0;
          acc_lo_d   = op_is_div ? mag_a : mag_b;
`ifdef MULDIV_ZERO_SHORTCUT_EN
          // Zero operandB: result is known, preload it and go straight to FIX.
          if (operandB == '0) begin
            state_d  = S_FIX;
            acc_hi_d = op_is_div ? mag_a : '0;
            acc_lo_d = op_is_div ? '1 : '0;
          end
`endif
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!rem_diff[WIDTH]) begin
            acc_hi_d = rem_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_STEP) state_d = S_FIX;
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        // A flush arriving with the write-back discards the result.
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div_zero_q ? '1 : (neg_lo_q ? (~acc_lo_q + 1'b1) : acc_lo_q);
            hi_d = neg_hi_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
          end else begin
            {hi_d, lo_d} = neg_lo_q ? prod_neg : prod_mag;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register: synchronous reset clears everything, including any operation in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Cycle numbering: cycle 0 is the cycle in which start is driven; values
// are sampled 1 time unit after each rising edge.
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        flush;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .flush(flush),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation and follow it to completion, checking latency and results.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int cyc;
    op = o; operandA = a; operandB = b; start = 1'b1;
    tick();
    cyc = 1;
    start = 1'b0; op = 2'(cyc + 1); operandA = 32'hDEADBEEF; operandB = 32'h13579BDF;
    check({tag, " busy c1"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, cyc, elat);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h after %0d cycles", tag, o, a, b, hi, lo, cyc);
  endtask

  initial begin
    int cyc;
    int n_done;
    logic [31:0] lo_keep;

    RST = 1'b1; start = 1'b0; op = 2'd0; operandA = '0; operandB = '0;
    flush = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; writeData = '0;
    tick(); tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    RST = 1'b0;

    // MTLO in IDLE
    loWrite = 1'b1; writeData = 32'h5555_0001;
    tick();
    loWrite = 1'b0;
    check("mtlo", lo, 32'h5555_0001);
    $display("txn mtlo lo=%h", lo);

    run_op("mult -1x2",  2'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("multu",      2'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 34);
    run_op("mult -3x-5", 2'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'd15, 34);
    run_op("div -7/2",   2'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op("div ovf",    2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    run_op("divu by 0",  2'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, ZLAT);
    run_op("div -8/0",   2'd2, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, ZLAT);
    run_op("multu x0",   2'd1, 32'h1234, 32'h0, 32'h0, 32'h0, ZLAT);

    // Flush mid-run: MTHI preload must survive, no done pulse.
    lo_keep = lo;
    hiWrite = 1'b1; writeData = 32'h0000AAAA;
    tick();
    hiWrite = 1'b0;
    check("mthi", hi, 32'h0000AAAA);
    op = 2'd0; operandA = 32'd5; operandB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy c11", {31'd0, busy}, 32'd0);
    n_done = 0;
    for (cyc = 11; cyc < 50; cyc++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check("flush no done", n_done, 32'd0);
    check("flush hi kept", hi, 32'h0000AAAA);
    check("flush lo kept", lo, lo_keep);
    $display("txn flush hi=%h lo=%h", hi, lo);

    // Start/MTHI while busy ignored; back-to-back start in the done cycle.
    op = 2'd1; operandA = 32'd3; operandB = 32'd5; start = 1'b1;
    tick();
    for (cyc = 1; cyc < 34; cyc++) begin
      if (cyc == 5) begin
        start = 1'b1; op = 2'd3; operandA = 32'd9; operandB = 32'd3;
        hiWrite = 1'b1; writeData = 32'h0000DEAD;
      end else begin
        start = 1'b0; hiWrite = 1'b0;
      end
      tick();
    end
    check("b2b done c34", {31'd0, done}, 32'd1);
    check("b2b lo 15", lo, 32'd15);
    check("b2b hi 0", hi, 32'd0);
    $display("txn multu 3x5 hi=%h lo=%h", hi, lo);
    op = 2'd3; operandA = 32'd9; operandB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b busy c35", {31'd0, busy}, 32'd1);
    for (cyc = 35; cyc < 68; cyc++) tick();
    check("b2b done c68", {31'd0, done}, 32'd1);
    check("b2b lo 3", lo, 32'd3);
    check("b2b hi 0 second", hi, 32'd0);
    $display("txn divu 9/3 hi=%h lo=%h", hi, lo);
    tick();

    // Reset in the middle of a divide.
    op = 2'd3; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc < 20; cyc++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst busy c21", {31'd0, busy}, 32'd0);
    check("rst done c21", {31'd0, done}, 32'd0);
    check("rst hi c21", hi, 32'd0);
    check("rst lo c21", lo, 32'd0);
    n_done = 0;
    for (cyc = 21; cyc < 60; cyc++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check("rst no done", n_done, 32'd0);
    $display("txn reset-abort hi=%h lo=%h", hi, lo);

    // Unit still works after the abort.
    run_op("divu post-rst", 2'd3, 32'd50, 32'd6, 32'd2, 32'd8, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage.
- Operand B is the ALU source mux output; operand A is register read 1.
- Executes MULT, MULTU, DIV and DIVU into private HI/LO registers with a start/busy/done handshake.
- The hazard unit stalls the pipeline on busy; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count = WIDTH; nominal latency = WIDTH+2.

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  request operation; sampled only in IDLE
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- operandA  input  WIDTH  multiplicand / dividend (register read 1)
- operandB  input  WIDTH  multiplier / divisor (alu_source_mux out)
- flush  input  1  abort the in-flight operation
- hiWrite  input  1  MTHI
- loWrite  input  1  MTLO
- writeData  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: when RST=1 at an edge, state=IDLE and busy=0, done=0, hi=0, lo=0; internal accumulators and counter cleared.
- RST has priority over all inputs, including mid-operation: the operation is discarded and no done is produced.
- States:
  - IDLE -> RUN when start=1. Operands are latched; signed ops store magnitudes plus the result signs.
  - RUN: 32 cycles, one radix-2 step per cycle. Mul is shift-add on unsigned magnitudes. Div is restoring shift-subtract.
  - RUN -> FIX when the 5-bit counter reaches 31 (counter wraps to 0).
  - FIX: applies two's-complement sign correction, writes hi/lo, -> IDLE.
- Timing: start sampled in cycle 0 -> busy=1 in cycles 1..33 -> hi/lo updated and done=1 in cycle 34, with state IDLE.
  - A start asserted in cycle 34 is accepted.
  - done is registered and never high while busy=1.
- start while busy: ignored and not queued.
- op values and operands are don't-care after cycle 0.
- Signed results:
  - Product = 64-bit two's complement, {hi,lo}.
  - Quotient (lo) sign = signA xor signB.
  - Remainder (hi) sign = signA; quotient truncates toward zero.
- Special cases:
  - 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU) -> lo=0xFFFFFFFF, hi=operandA; full latency still applies.
- flush:
  - In RUN or FIX: next state IDLE, busy=0 next cycle, no done, hi/lo unchanged.
  - In IDLE: suppresses that cycle's start.
  - Flush and the FIX-state write in the same cycle: flush wins.
- hiWrite/loWrite:
  - Honoured only in IDLE; ignored while busy.
  - If start and hiWrite occur in the same cycle, hi takes writeData first and is later overwritten by the result.
- No combinational path from any input to busy, done, hi or lo.

Optional Feature:
- MULDIV_ZERO_SHORTCUT_EN.
- Defined: if operandB==0 at start, the unit skips RUN and goes IDLE -> FIX directly.
  - busy=1 in cycle 1 only; done=1 in cycle 2.
  - MULT/MULTU results: hi=lo=0.
  - DIV/DIVU results: per the divide-by-zero rule above.
- Undefined: operandB==0 takes the full 34-cycle latency with identical results.

Test Plan:
- MULT 0xFFFFFFFF x 0x00000002 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234; done at cycle 34 (cycle 2 with MULDIV_ZERO_SHORTCUT_EN).
- Preload hi=0xAAAA via MTHI, start MULT, assert flush in cycle 10 -> busy=0 in cycle 11; done never pulses; hi=0xAAAA is retained.
- Start MULTU 3x5; pulse start with DIVU 9/3 and hiWrite in cycle 5 -> both ignored. At cycle 34, lo=15, hi=0. Back-to-back start in cycle 34 (DIVU 9/3) -> done at cycle 68, lo=3, hi=0.
- RST asserted in cycle 20 of a DIVU -> cycle 21: busy=0, done=0, hi=lo=0. No done is produced for the aborted operation.
